// File: rtl/pipe_hold_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hold_ctrl_pkg
//  Description : Shared hold-flag encodings and pipeline hold patterns.
//  Revision    : 1.0
// ============================================================================
package pipe_hold_ctrl_pkg;

    localparam int c_holdpip_w   = 2;
    localparam int c_inst_addr_w = 32;

    localparam logic [c_holdpip_w-1:0] c_hold_none  = 2'b00;
    localparam logic [c_holdpip_w-1:0] c_hold_wait  = 2'b01;
    localparam logic [c_holdpip_w-1:0] c_hold_flush = 2'b10;

    typedef struct packed {
        logic [c_holdpip_w-1:0] pc;
        logic [c_holdpip_w-1:0] if_id;
        logic [c_holdpip_w-1:0] id_ex;
        logic [c_holdpip_w-1:0] ex_mem;
        logic [c_holdpip_w-1:0] mem_wb;
    } hold_vec_t;

    localparam hold_vec_t c_pat_idle  = '{c_hold_none,  c_hold_none,  c_hold_none,  c_hold_none,  c_hold_none};
    localparam hold_vec_t c_pat_reset = '{c_hold_flush, c_hold_flush, c_hold_flush, c_hold_flush, c_hold_flush};
    // Bus wait freezes everything upstream of MEM and sends a bubble to WB.
    localparam hold_vec_t c_pat_memw  = '{c_hold_wait,  c_hold_wait,  c_hold_wait,  c_hold_wait,  c_hold_flush};
    localparam hold_vec_t c_pat_divw  = '{c_hold_wait,  c_hold_wait,  c_hold_wait,  c_hold_flush, c_hold_none};
    localparam hold_vec_t c_pat_jump  = '{c_hold_none,  c_hold_flush, c_hold_flush, c_hold_none,  c_hold_none};
    localparam hold_vec_t c_pat_luse  = '{c_hold_wait,  c_hold_wait,  c_hold_flush, c_hold_none,  c_hold_none};
    localparam hold_vec_t c_pat_abort = '{c_hold_none,  c_hold_none,  c_hold_none,  c_hold_flush, c_hold_flush};

endpackage
`default_nettype wire

// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hold_ctrl
//  Description : 5-stage pipeline hold/flush sequencer with bus-wait watchdog.
//  Revision    : 1.0
// ============================================================================
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_load_use_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        ex_div_start_i,
    input  logic        ex_div_done_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic [1:0]  hold_pc_o,
    output logic [1:0]  hold_if_id_o,
    output logic [1:0]  hold_id_ex_o,
    output logic [1:0]  hold_ex_mem_o,
    output logic [1:0]  hold_mem_wb_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_err_o
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_mem_wait = 2'd1;
    localparam logic [1:0] c_st_div_wait = 2'd2;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(BUS_TIMEOUT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_wdt_cnt;
    logic             r_bus_err;

    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_abort;
    hold_vec_t        w_hold;
    logic             w_jump_flag;
    logic [31:0]      w_jump_addr;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_wdt_cnt;
        w_abort      = 1'b0;
        w_hold       = c_pat_idle;
        w_jump_flag  = 1'b0;
        w_jump_addr  = '0;
        case (r_state)
            c_st_run: begin
                if (mem_req_i && !mem_ready_i) begin
                    w_hold       = c_pat_memw;
                    w_next_state = c_st_mem_wait;
                    w_next_cnt   = CNT_W'(1);
                end else if (ex_div_start_i) begin
                    w_hold       = c_pat_divw;
                    w_next_state = c_st_div_wait;
                end else if (ex_jump_i) begin
                    w_hold       = c_pat_jump;
                    w_jump_flag  = 1'b1;
                    w_jump_addr  = ex_jump_addr_i;
                end else if (id_load_use_i) begin
                    w_hold       = c_pat_luse;
                end
            end
            c_st_mem_wait: begin
                if (mem_ready_i) begin
                    w_next_state = c_st_run;
                    w_next_cnt   = '0;
                end else if (r_wdt_cnt >= c_timeout) begin
                    // Drop the hung access: no writeback, upstream resumes.
                    w_hold       = c_pat_abort;
                    w_abort      = 1'b1;
                    w_next_state = c_st_run;
                    w_next_cnt   = '0;
                end else begin
                    w_hold       = c_pat_memw;
                    w_next_cnt   = r_wdt_cnt + CNT_W'(1);
                end
            end
            c_st_div_wait: begin
                if (ex_div_done_i) begin
                    w_next_state = c_st_run;
                end else begin
                    w_hold       = c_pat_divw;
                end
            end
            default: begin
                w_next_state = c_st_run;
                w_next_cnt   = '0;
            end
        endcase
        // Reset overrides decode so every register loads its bubble.
        if (!rst_n) begin
            w_hold      = c_pat_reset;
            w_jump_flag = 1'b0;
            w_jump_addr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_run;
            r_wdt_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_wdt_cnt <= w_next_cnt;
            r_bus_err <= w_abort;
        end
    end

    assign hold_pc_o     = w_hold.pc;
    assign hold_if_id_o  = w_hold.if_id;
    assign hold_id_ex_o  = w_hold.id_ex;
    assign hold_ex_mem_o = w_hold.ex_mem;
    assign hold_mem_wb_o = w_hold.mem_wb;
    assign jump_flag_o   = w_jump_flag;
    assign jump_addr_o   = w_jump_addr;
    assign bus_err_o     = r_bus_err;

endmodule
`default_nettype wire

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Collects stall and redirect requests from ID (load-use), EX (jump, multi-cycle divide) and MEM (bus wait).
- Drives one hold flag per pipeline register: pc, if_id, id_ex, ex_mem, mem_wb. Each flag encodes none, wait or flush.
- Contains a small state machine for multi-cycle stalls, plus a bus-wait watchdog that aborts hung memory accesses.

Parameters:
- BUS_TIMEOUT, 16: maximum cycles spent in the memory-wait state before abort. Legal range 2..255.
- CNT_W, 8: width of the watchdog counter. Must satisfy 2^CNT_W > BUS_TIMEOUT.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- id_load_use_i  input  1  load-use hazard detected in ID
- ex_jump_i  input  1  taken branch/jump resolved in EX
- ex_jump_addr_i  input  32  redirect target
- ex_div_start_i  input  1  divide instruction entering execution
- ex_div_done_i  input  1  divider result valid (single-cycle pulse)
- mem_req_i  input  1  MEM stage has an outstanding load/store
- mem_ready_i  input  1  bus accepts/returns the access this cycle
- hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o  output  `holdpip_bus each  per-register hold flag
- jump_flag_o  output  1  PC redirect strobe
- jump_addr_o  output  32  PC redirect target
- bus_err_o  output  1  one-cycle pulse on watchdog abort

Interface decision:
- One clock; reset is asynchronous and active-low. Ports are clk and rst_n.

Behaviour:
- Hold flag meanings: `hold_none` = register loads. `hold_wait` = register keeps its value. `hold_flush` = register loads its default (bubble) on the next edge.
- Registered state: state (RUN, MEM_WAIT, DIV_WAIT), wdt_cnt, bus_err_o.
- Combinational outputs: hold flags, jump_flag_o, jump_addr_o. They are decoded from state and the current inputs, so a stall acts in the same cycle it is requested.
- Reset (rst_n low), effective immediately and asynchronously:
  - state = RUN, wdt_cnt = 0, bus_err_o = 0.
  - All five hold outputs = `hold_flush`; jump_flag_o = 0.
  - Reset mid-stall abandons the stall with no pending effect.
- RUN state, first matching rule wins:
  1. mem_req_i & !mem_ready_i: pc, if_id, id_ex, ex_mem = wait; mem_wb = flush. Next state MEM_WAIT, wdt_cnt = 1.
  2. ex_div_start_i: pc, if_id, id_ex = wait; ex_mem = flush; mem_wb = none. Next state DIV_WAIT.
  3. ex_jump_i: jump_flag_o = 1; jump_addr_o = ex_jump_addr_i; if_id, id_ex = flush; others none.
  4. id_load_use_i: pc, if_id = wait; id_ex = flush; others none.
  5. Otherwise all none.
- jump_addr_o = 0 whenever jump_flag_o = 0.
- MEM_WAIT:
  - While mem_ready_i = 0 and wdt_cnt < BUS_TIMEOUT: drive the rule-1 pattern and increment wdt_cnt.
  - When mem_ready_i = 1: all flags none this cycle; next state RUN; wdt_cnt = 0.
  - When mem_ready_i = 0 and wdt_cnt == BUS_TIMEOUT: ex_mem and mem_wb = flush (the faulting access is dropped, no writeback); pc, if_id, id_ex = none. Set bus_err_o = 1 for exactly the next cycle; next state RUN; wdt_cnt = 0.
  - All other requests are ignored in MEM_WAIT. EX and ID are held, so their requests re-present after release.
- DIV_WAIT:
  - While ex_div_done_i = 0: pc, if_id, id_ex = wait; ex_mem = flush; mem_wb = none. No timeout.
  - When ex_div_done_i = 1: all none; next state RUN.
  - jump, load-use and div_start are ignored in this state.
  - mem_req_i is ignored here: MEM holds a bubble by construction. The bench asserts mem_req_i = 0 in DIV_WAIT after the first cycle.
- Simultaneous events in RUN: a memory stall outranks divide, jump and load-use. Jump outranks load-use, since the instruction in ID is squashed anyway.
- Same-cycle completion: div_start and div_done in the same cycle is illegal; the bench asserts against it. mem_req_i & mem_ready_i in RUN causes no stall.
- Latency: stall decisions take 0 cycles. State changes take 1 cycle. bus_err_o rises on the edge that ends MEM_WAIT.

Decomposition:
- Shared define.v carries:
  - `hold_none` = 2'b00, `hold_wait` = 2'b01, `hold_flush` = 2'b10
  - `holdpip_bus` = 1:0
  - `inst_addr_bus`
- State encodings are localparams inside the module.
- No sub-module: the watchdog counter and the FSM are small enough to stay inline.

Test Plan:
- Reset: hold rst_n low with arbitrary inputs -> all holds = 2'b10, jump_flag_o = 0, bus_err_o = 0. Release rst_n with idle inputs -> all holds = 2'b00 in the same cycle.
- Load-use, then jump: id_load_use_i = 1 for 1 cycle -> pc = if_id = wait, id_ex = flush. Next, ex_jump_i = 1 with addr 0x0000_0100 and load_use = 1 -> jump_flag_o = 1, addr 0x100, if_id = id_ex = flush, pc = none.
- Bus wait: mem_req_i = 1, mem_ready_i = 0 for 3 cycles, then ready = 1 -> 3 cycles of wait pattern with mem_wb flush, then all none, state RUN, bus_err_o never asserted.
- Watchdog: mem_req_i = 1, mem_ready_i held 0 with BUS_TIMEOUT = 4 -> abort cycle drives ex_mem = mem_wb = flush; bus_err_o = 1 for exactly 1 cycle; next stall restarts wdt_cnt from 1.
- Divide: ex_div_start_i pulse, ex_div_done_i after 33 cycles, ex_jump_i asserted throughout -> no jump_flag_o during DIV_WAIT; ex_mem = flush for 33 cycles. jump_flag_o = 1 on the first RUN cycle after done.
- Priority/reset mid-operation: mem stall, div_start and jump together -> MEM_WAIT entered, jump suppressed. Pulse rst_n low mid-MEM_WAIT -> state RUN, wdt_cnt = 0, no bus_err_o.
